sensor_conditioner: RTL and testbench
=====================================

// Module: sensor_conditioner
// PURPOSE
//   Upstream stage for the intersection controller. Debounces the five raw
//   vehicle/pedestrian sensors and latches each debounced press or arrival as
//   a sticky request. The state machine consumes requests[4:0] as its
//   sensors[4:0] input and pulses req_clr when it has served a phase.
// PARAMETERS
//   NUM_SENSORS      5   channel count; bit order fixed by traffic_pkg
//   DEBOUNCE_CYCLES  4   consecutive samples needed to accept a level change; >=1
// PORTS
//   clk          in   1            single clock; all state on rising edge
//   rst          in   1            synchronous reset, active-high
//   sensors_raw  in   NUM_SENSORS  raw sensors (async when SENSOR_SYNC_EN defined)
//   req_clr      in   NUM_SENSORS  1-cycle clear pulses from the FSM, per channel
//   level        out  NUM_SENSORS  debounced sensor level
//   requests     out  NUM_SENSORS  sticky requests; drive the FSM sensors input
//   any_request  out  1            registered OR of the next value of requests
// BEHAVIOUR
//   - Reset (rst=1 at an edge): level, requests, any_request = 0;
//     all debounce counters = 0; synchronizer flops = 0.
//   - Per channel, s = sampled raw bit. Counter cnt has width
//     $clog2(DEBOUNCE_CYCLES+1).
//   - s == level: cnt <= 0.
//   - s != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - s != level and cnt == DEBOUNCE_CYCLES-1: level <= s and cnt <= 0.
//   - Net effect: level toggles on the DEBOUNCE_CYCLES-th consecutive
//     differing sample. Any agreeing sample restarts the count, so a glitch
//     shorter than DEBOUNCE_CYCLES never reaches level.
//   - DEBOUNCE_CYCLES=1: level follows s with 1 edge of latency.
//   - Rise event: on the edge where level goes 0->1, requests[i] <= 1.
//     Falling edges of level never change requests.
//   - Clear: req_clr[i]=1 at an edge with no rise event forces requests[i] <= 0.
//   - Simultaneous rise event and req_clr[i]: the rise wins and requests[i]=1,
//     so a fresh arrival is never lost.
//   - requests[i] already 1 and another rise event: stays 1. No counting or
//     overflow.
//   - Holding a sensor high after a clear does not re-request. A new
//     0->1 debounced transition is required.
//   - Latency: raw rise to requests, DEBOUNCE_CYCLES edges (+2 with sync).
//   - any_request is registered alongside requests; no extra cycle.
//   - rst mid-debounce: partial counts are discarded and pending requests are
//     dropped.
//   - Channels are fully independent; every bit position behaves identically.
// CONFIGURATION
//   SENSOR_SYNC_EN defined: a 2-flop synchronizer per channel sits ahead of
//     the debouncer, and s is the second flop. Adds 2 edges of latency to
//     level and requests.
//   SENSOR_SYNC_EN undefined: s = sensors_raw directly. The inputs must
//     already be synchronous to clk.
// STRUCTURE
//   - traffic_pkg (traffic_defs.vh) holds the shared definitions:
//     - sensor index constants: SNS_LEFT_MAIN=0, SNS_LEFT_CROSS=1,
//       SNS_TRAFFIC_CROSS=2, SNS_WALK_MAIN=3, SNS_WALK_CROSS=4;
//     - NUM_SENSORS=5;
//     - the light-encoding constants shared with the FSM.
//   - Sub-module debounce_channel holds one channel's sync/counter/level/
//     request logic. sensor_conditioner instantiates it NUM_SENSORS times via
//     generate, plus the any_request OR.
// TESTING (DEBOUNCE_CYCLES=4, SENSOR_SYNC_EN undefined unless stated)
//   1. rst=1 for 2 cycles with sensors_raw=5'b11111: level, requests and
//      any_request are 0 throughout; the count starts after rst falls.
//   2. sensors_raw[3] high for 3 cycles, then low: level[3] and requests[3]
//      stay 0 (glitch rejected).
//   3. sensors_raw[0] held high: level[0] and requests[0] rise on the 4th
//      edge, together with any_request. Then pulse req_clr[0]: requests[0]=0
//      next edge while level[0] stays 1.
//   4. Debounced rise on ch2 at the same edge req_clr[2]=1: requests[2]=1.
//      Pulse req_clr[2] again: it clears.
//   5. Ch1 and ch4 rise 2 cycles apart: requests=5'b00010, then 5'b10010.
//      Assert rst mid-debounce on ch4's next rise: all outputs return to 0.
//   6. SENSOR_SYNC_EN defined: the ch0 rise reaches requests[0] on the 6th
//      edge after raw rises.

Source files
------------

// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Shared intersection-controller definitions (sensor indices,
//               channel count, light encodings).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam int NUM_SENSORS       = 5;

    localparam int SNS_LEFT_MAIN     = 0;
    localparam int SNS_LEFT_CROSS    = 1;
    localparam int SNS_TRAFFIC_CROSS = 2;
    localparam int SNS_WALK_MAIN     = 3;
    localparam int SNS_WALK_CROSS    = 4;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10,
        LIGHT_OFF    = 2'b11
    } light_t;

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : One sensor channel: optional 2-flop synchronizer (SENSOR_SYNC_EN),
//               consecutive-sample debouncer and sticky request latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_clr,
    output logic o_level,
    output logic o_req,
    output logic o_req_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_s;
    logic             w_rise;
    logic             w_req_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_req;

`ifdef SENSOR_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = i_raw;
`endif

    // A rise beats a simultaneous clear so a fresh arrival is never lost.
    assign w_rise     = w_s & ~r_level & (r_cnt == c_cnt_max);
    assign w_req_next = w_rise | (r_req & ~i_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_req <= w_req_next;
        end
    end

    assign o_level    = r_level;
    assign o_req      = r_req;
    assign o_req_next = w_req_next;

endmodule

`default_nettype wire

// File: rtl/sensor_conditioner.sv
// ============================================================================
// Module      : sensor_conditioner
// Description : Debounces the raw intersection sensors into sticky requests.
//               Optional input synchronizers enabled by SENSOR_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_conditioner #(
    parameter int NUM_SENSORS     = traffic_pkg::NUM_SENSORS,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] sensors_raw,
    input  logic [NUM_SENSORS-1:0] req_clr,
    output logic [NUM_SENSORS-1:0] level,
    output logic [NUM_SENSORS-1:0] requests,
    output logic                   any_request
);

    logic [NUM_SENSORS-1:0] w_req_next;
    logic                   r_any;

    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_raw      (sensors_raw[gi]),
            .i_clr      (req_clr[gi]),
            .o_level    (level[gi]),
            .o_req      (requests[gi]),
            .o_req_next (w_req_next[gi])
        );
    end

    // Built from the next request vector so it lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_req_next;
        end
    end

    assign any_request = r_any;

endmodule

`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
// ============================================================================
// Module      : tb_sensor_conditioner
// Description : Randomized and directed bench for sensor_conditioner with a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_conditioner;

    localparam int N = 5;
    localparam int D = 4;
`ifdef SENSOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sensors_raw = '0;
    logic [N-1:0] req_clr = '0;
    logic [N-1:0] level;
    logic [N-1:0] requests;
    logic         any_request;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int           run_len [N];
    logic [N-1:0] m_lvl = '0;
    logic [N-1:0] m_req = '0;
    logic         m_any = 1'b0;
    logic [N-1:0] m_p1  = '0;
    logic [N-1:0] m_p2  = '0;

    sensor_conditioner #(
        .NUM_SENSORS    (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensors_raw(sensors_raw),
        .req_clr    (req_clr),
        .level      (level),
        .requests   (requests),
        .any_request(any_request)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Level flips after D consecutive disagreeing samples; rise sets, clear resets.
    task automatic model_step();
        logic s;
        logic rise;
        if (rst) begin
            for (int i = 0; i < N; i++) run_len[i] = 0;
            m_lvl = '0; m_req = '0; m_any = 1'b0; m_p1 = '0; m_p2 = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                s    = (LAT == 2) ? m_p2[i] : sensors_raw[i];
                rise = 1'b0;
                if (s != m_lvl[i]) begin
                    run_len[i] = run_len[i] + 1;
                    if (run_len[i] >= D) begin
                        rise       = s;
                        m_lvl[i]   = s;
                        run_len[i] = 0;
                    end
                end else begin
                    run_len[i] = 0;
                end
                m_req[i] = rise | (m_req[i] & ~req_clr[i]);
            end
            m_p2  = m_p1;
            m_p1  = sensors_raw;
            m_any = |m_req;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("level", 32'(level), 32'(m_lvl));
        check("requests", 32'(requests), 32'(m_req));
        check("any_request", 32'(any_request), 32'(m_any));
    endtask

    initial begin
        int lat;
        // Reset held with all sensors high: nothing may move.
        sensors_raw = 5'b11111;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("rst_level", 32'(level), 32'd0);
            check("rst_req", 32'(requests), 32'd0);
            check("rst_any", 32'(any_request), 32'd0);
        end
        rst = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            cyc();
            if (requests == 5'b11111) lat = k;
        end
        check("rise_latency", 32'(lat), 32'(D + LAT));
        check("rise_any", 32'(any_request), 32'd1);

        rst = 1'b1; sensors_raw = '0;
        cyc(); cyc();
        rst = 1'b0;

        // Glitch of 3 samples on ch3.
        sensors_raw[3] = 1'b1;
        repeat (3) cyc();
        sensors_raw[3] = 1'b0;
        repeat (8) cyc();
        check("glitch_level3", 32'(level[3]), 32'd0);
        check("glitch_req3", 32'(requests[3]), 32'd0);

        // Ch0 held high, then cleared while level stays up.
        sensors_raw[0] = 1'b1;
        for (int k = 1; k <= D + LAT; k++) begin
            cyc();
            if (k == D + LAT - 1) check("ch0_early", 32'(requests[0]), 32'd0);
        end
        check("ch0_req", 32'(requests[0]), 32'd1);
        check("ch0_level", 32'(level[0]), 32'd1);
        check("ch0_any", 32'(any_request), 32'd1);
        req_clr[0] = 1'b1;
        cyc();
        req_clr[0] = 1'b0;
        check("ch0_clr_req", 32'(requests[0]), 32'd0);
        check("ch0_clr_level", 32'(level[0]), 32'd1);
        check("ch0_clr_any", 32'(any_request), 32'd0);
        repeat (3) cyc();
        check("ch0_no_rereq", 32'(requests[0]), 32'd0);

        // Ch2 rise coincides with a clear: rise wins.
        sensors_raw[2] = 1'b1;
        for (int k = 1; k <= D + LAT; k++) begin
            if (k == D + LAT) req_clr[2] = 1'b1;
            cyc();
        end
        req_clr[2] = 1'b0;
        check("ch2_rise_wins", 32'(requests[2]), 32'd1);
        req_clr[2] = 1'b1;
        cyc();
        req_clr[2] = 1'b0;
        check("ch2_clr", 32'(requests[2]), 32'd0);

        // Ch1 then ch4, two cycles apart.
        sensors_raw = '0;
        repeat (D + LAT + 2) cyc();
        sensors_raw[1] = 1'b1;
        for (int k = 1; k <= D + LAT + 2; k++) begin
            if (k == 3) sensors_raw[4] = 1'b1;
            cyc();
            if (k == D + LAT) check("ch1_first", 32'(requests), 32'b00010);
        end
        check("ch1_ch4", 32'(requests), 32'b10010);
        sensors_raw[4] = 1'b0;
        repeat (D + LAT + 1) cyc();
        sensors_raw[4] = 1'b1;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_mid_level", 32'(level), 32'd0);
        check("rst_mid_req", 32'(requests), 32'd0);
        check("rst_mid_any", 32'(any_request), 32'd0);

        // Random phase: slow-moving sensors, sparse clears, rare resets.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) sensors_raw[i] = ~sensors_raw[i];
            for (int i = 0; i < N; i++) req_clr[i] = ($urandom_range(7) == 0);
            rst = ($urandom_range(149) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
